// File: rtl/gate_tt_sequencer.sv
// Truth-table sequencer for a 2-input combinational gate: walks vectors 00..11,
// holds each for a settle window, samples the gate and scores it against an expected table.
module gate_tt_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] expected,
  input  logic       dut_out,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] observed,
  output logic [2:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_exp, w_exp_nxt;
  logic [1:0]       r_idx, w_idx_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_vec, w_vec_nxt;
  logic [3:0]       r_observed, w_observed_nxt;
  logic [2:0]       r_err, w_err_nxt;
  logic             r_pass, w_pass_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             w_miss;

  assign w_miss = (dut_out != r_exp[r_idx]);

  // NOTE: every next-value is defaulted to its current register first, so no
  // path through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_exp_nxt      = r_exp;
    w_idx_nxt      = r_idx;
    w_cnt_nxt      = r_cnt;
    w_vec_nxt      = r_vec;
    w_observed_nxt = r_observed;
    w_err_nxt      = r_err;
    w_pass_nxt     = r_pass;

    unique case (r_state)
      S_IDLE: begin
        // abort in IDLE does nothing but still suppresses a coincident start
        if (start && !abort) begin
          w_exp_nxt      = expected;
          w_idx_nxt      = 2'd0;
          w_cnt_nxt      = '0;
          w_observed_nxt = 4'b0000;
          w_err_nxt      = 3'd0;
          w_pass_nxt     = 1'b0;
          w_vec_nxt      = 2'b00;
          w_state_nxt    = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_state_nxt = S_SAMPLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_SAMPLE: begin
        w_observed_nxt[r_idx] = dut_out;
        if (w_miss) begin
          w_err_nxt = r_err + 3'd1;
        end
        if (r_idx == 2'd3) begin
          // pass is resolved with the last sample included so it is valid alongside done
          w_pass_nxt  = (w_err_nxt == 3'd0);
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt   = r_idx + 2'd1;
          w_vec_nxt   = r_idx + 2'd1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SETTLE;
        end
      end
      S_DONE: begin
        w_vec_nxt   = 2'b00;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Abort discards this cycle's work but keeps the partial results already scored.
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt    = S_IDLE;
      w_vec_nxt      = 2'b00;
      w_pass_nxt     = 1'b0;
      w_observed_nxt = r_observed;
      w_err_nxt      = r_err;
    end

    w_busy_nxt = (w_state_nxt == S_SETTLE) || (w_state_nxt == S_SAMPLE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_exp      <= 4'b0000;
      r_idx      <= 2'd0;
      r_cnt      <= '0;
      r_vec      <= 2'b00;
      r_observed <= 4'b0000;
      r_err      <= 3'd0;
      r_pass     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_exp      <= w_exp_nxt;
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_vec      <= w_vec_nxt;
      r_observed <= w_observed_nxt;
      r_err      <= w_err_nxt;
      r_pass     <= w_pass_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign dut_a     = r_vec[1];
  assign dut_b     = r_vec[0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign observed  = r_observed;
  assign err_count = r_err;

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Randomised self-checking bench: two sequencers (settle 2 and settle 1), each driving
// its own table-defined gate model, scored against a run-level reference model.
module tb_gate_tt_sequencer;

  logic       clk;
  logic       rst_n;
  logic [1:0] start_v;
  logic [1:0] abort_v;
  logic [3:0] expected_v [2];
  logic [3:0] gate_tt [2];
  logic [1:0] out_v;
  logic [1:0] a_v, b_v, busy_v, done_v, pass_v;
  logic [1:0][3:0] obs_v;
  logic [1:0][2:0] err_v;

  int checks = 0;
  int errors = 0;

  gate_tt_sequencer #(.SETTLE_CYCLES(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
    .expected(expected_v[0]), .dut_out(out_v[0]), .dut_a(a_v[0]), .dut_b(b_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .observed(obs_v[0]), .err_count(err_v[0])
  );

  gate_tt_sequencer #(.SETTLE_CYCLES(1), .CNT_W(8)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
    .expected(expected_v[1]), .dut_out(out_v[1]), .dut_a(a_v[1]), .dut_b(b_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .observed(obs_v[1]), .err_count(err_v[1])
  );

  // Gate under test: output is the table bit selected by {a,b}.
  assign out_v[0] = gate_tt[0][{a_v[0], b_v[0]}];
  assign out_v[1] = gate_tt[1][{a_v[1], b_v[1]}];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int popcount4(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic check_idle_zero(input int k, input string tag);
    check({tag, "_busy"}, 32'(busy_v[k]), 0);
    check({tag, "_done"}, 32'(done_v[k]), 0);
    check({tag, "_pass"}, 32'(pass_v[k]), 0);
    check({tag, "_ab"},   32'({a_v[k], b_v[k]}), 0);
    check({tag, "_obs"},  32'(obs_v[k]), 0);
    check({tag, "_err"},  32'(err_v[k]), 0);
  endtask

  // One run on instance k (settle s). t_abort>0: abort sampled on edge t_abort after the start edge.
  task automatic run(input int k, input int s, input logic [3:0] e, input logic [3:0] g,
                     input int t_abort, input bit noise);
    int         len  = 4 * (s + 1);
    int         last = (t_abort > 0) ? t_abort : len + 1;
    int         n;
    logic [3:0] mask;
    logic [3:0] exp_obs;
    int         exp_err;
    int         exp_pass;
    if (t_abort > 0) begin
      n    = (t_abort - 1) / (s + 1);
      mask = 4'((1 << n) - 1);
    end else begin
      mask = 4'b1111;
    end
    exp_obs  = g & mask;
    exp_err  = popcount4((g ^ e) & mask);
    exp_pass = (t_abort == 0 && exp_err == 0) ? 1 : 0;

    @(negedge clk);
    gate_tt[k]    = g;
    expected_v[k] = e;
    start_v[k]    = 1'b1;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      start_v[k]    = noise && (c < last) && ($urandom_range(0, 2) == 0);
      abort_v[k]    = (t_abort > 0) && (c == t_abort - 1);
      expected_v[k] = 4'($urandom);
      if (t_abort > 0 && c == t_abort) begin
        check("abort_busy", 32'(busy_v[k]), 0);
        check("abort_done", 32'(done_v[k]), 0);
        check("abort_pass", 32'(pass_v[k]), 0);
        check("abort_ab",   32'({a_v[k], b_v[k]}), 0);
        check("abort_obs",  32'(obs_v[k]), 32'(exp_obs));
        check("abort_err",  32'(err_v[k]), 32'(exp_err));
      end else if (c < len) begin
        check("run_busy", 32'(busy_v[k]), 1);
        check("run_done", 32'(done_v[k]), 0);
        check("run_ab",   32'({a_v[k], b_v[k]}), 32'(c / (s + 1)));
        if (c == 0) begin
          check("start_obs_clr",  32'(obs_v[k]), 0);
          check("start_err_clr",  32'(err_v[k]), 0);
          check("start_pass_clr", 32'(pass_v[k]), 0);
        end
      end else if (c == len) begin
        check("done_pulse", 32'(done_v[k]), 1);
        check("done_busy",  32'(busy_v[k]), 0);
      end else begin
        check("end_done", 32'(done_v[k]), 0);
        check("end_busy", 32'(busy_v[k]), 0);
        check("end_ab",   32'({a_v[k], b_v[k]}), 0);
        check("end_obs",  32'(obs_v[k]), 32'(exp_obs));
        check("end_err",  32'(err_v[k]), 32'(exp_err));
        check("end_pass", 32'(pass_v[k]), 32'(exp_pass));
      end
    end
    start_v[k] = 1'b0;
    abort_v[k] = 1'b0;
    repeat (2) @(negedge clk);
    check("hold_done", 32'(done_v[k]), 0);
    check("hold_busy", 32'(busy_v[k]), 0);
    check("hold_obs",  32'(obs_v[k]), 32'(exp_obs));
    check("hold_err",  32'(err_v[k]), 32'(exp_err));
    check("hold_pass", 32'(pass_v[k]), 32'(exp_pass));
  endtask

  initial begin
    int k, s, t;
    rst_n         = 1'b0;
    start_v       = 2'b00;
    abort_v       = 2'b00;
    expected_v[0] = 4'b0000;
    expected_v[1] = 4'b0000;
    gate_tt[0]    = 4'b1001;
    gate_tt[1]    = 4'b1001;
    repeat (2) @(negedge clk);
    check_idle_zero(0, "rst0");
    check_idle_zero(1, "rst1");
    rst_n = 1'b1;

    // Directed cases on the settle-2 instance (XNOR table is 4'b1001).
    run(0, 2, 4'b1001, 4'b1001, 0, 1'b0);
    run(0, 2, 4'b1001, 4'b0000, 0, 1'b0);
    run(0, 2, 4'b0110, 4'b1001, 0, 1'b0);
    run(0, 2, 4'b1001, 4'b1001, 0, 1'b0);
    run(0, 2, 4'b1001, 4'b1001, 0, 1'b1);
    run(0, 2, 4'b1001, 4'b1001, 8, 1'b0);

    // Start accepted in IDLE while abort is high must be suppressed.
    @(negedge clk);
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    check("idle_abort_busy", 32'(busy_v[0]), 0);
    check("idle_abort_obs",  32'(obs_v[0]), 32'(4'b0001));

    // Reset in the middle of a run.
    @(negedge clk);
    gate_tt[0]    = 4'b1001;
    expected_v[0] = 4'b1001;
    start_v[0]    = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", 32'(busy_v[0]), 1);
    rst_n = 1'b0;
    #1;
    check_idle_zero(0, "midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", 32'(busy_v[0]), 0);
    check("post_rst_done", 32'(done_v[0]), 0);

    // Settle-1 instance.
    run(1, 1, 4'b1001, 4'b1001, 0, 1'b0);

    // Randomised runs on both instances.
    for (int r = 0; r < 24; r++) begin
      k = r % 2;
      s = (k == 0) ? 2 : 1;
      t = 0;
      if ($urandom_range(0, 2) == 0) begin
        t = int'($urandom_range(0, 3)) * (s + 1) + int'($urandom_range(1, s));
      end
      run(k, s, 4'($urandom), 4'($urandom), t, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
